// File: rtl/qed_pkg.sv
// Shared definitions for the QED consistency checker: sweep FSM states and the
// default original/duplicate register mapping.
package qed_pkg;

  localparam int QED_FIRST_REG  = 1;
  localparam int QED_LAST_REG   = 15;
  localparam int QED_DUP_OFFSET = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_HALT
  } qed_state_e;

endpackage

// File: rtl/qed_consistency_checker_if.sv
// Commit stream and register-file pair read port seen by the QED checker.
// The master side is the checker; the slave side is the pipeline / register file.
interface qed_consistency_checker_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              commit_vld;
  logic              commit_dup;
  logic              pipe_empty;
  logic              rf_rd_req;
  logic [REG_AW-1:0] rf_rd_addr_a;
  logic [REG_AW-1:0] rf_rd_addr_b;
  logic              rf_rd_vld;
  logic [DATA_W-1:0] rf_rd_data_a;
  logic [DATA_W-1:0] rf_rd_data_b;

  modport master (
    input  commit_vld, commit_dup, pipe_empty,
    output rf_rd_req, rf_rd_addr_a, rf_rd_addr_b,
    input  rf_rd_vld, rf_rd_data_a, rf_rd_data_b
  );

  modport slave (
    output commit_vld, commit_dup, pipe_empty,
    input  rf_rd_req, rf_rd_addr_a, rf_rd_addr_b,
    output rf_rd_vld, rf_rd_data_a, rf_rd_data_b
  );
endinterface

// File: rtl/qed_commit_tracker.sv
// Counts originals retired ahead of their duplicates and flags protocol errors.
// consistent/pend_zero look at the post-commit count so a same-cycle commit is seen.
module qed_commit_tracker #(
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic commit_vld,
  input  logic commit_dup,
  input  logic sweep_start,
  output logic pend_zero,
  output logic consistent,
  output logic qed_err
);
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] pend_nxt;
  logic             dirty;
  logic             dirty_set;
  logic             proto_err;

  // NOTE: every always_comb output gets a default first, otherwise a path that skips it infers a latch.
  always_comb begin
    pend_nxt  = pend;
    dirty_set = dirty;
    proto_err = 1'b0;
    if (ena && commit_vld) begin
      if (commit_dup) begin
        // A duplicate with nothing outstanding is rejected outright, so it cannot arm a sweep.
        if (pend == '0) begin
          proto_err = 1'b1;
        end else begin
          pend_nxt  = pend - 1'b1;
          dirty_set = 1'b1;
        end
      end else begin
        if (&pend) proto_err = 1'b1;
        else       pend_nxt  = pend + 1'b1;
        dirty_set = 1'b1;
      end
    end
  end

  assign pend_zero  = (pend_nxt == '0);
  assign consistent = pend_zero && dirty_set;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend    <= '0;
      dirty   <= 1'b0;
      qed_err <= 1'b0;
    end else begin
      pend    <= ena ? pend_nxt : '0;
      dirty   <= ena && dirty_set && !sweep_start;
      qed_err <= qed_err || proto_err;
    end
  end
endmodule

// File: rtl/qed_consistency_checker.sv
// QED back end: waits for a consistent commit state, freezes fetch, compares
// every original/duplicate register pair and reports pass or the first mismatch.
module qed_consistency_checker
  import qed_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int FIRST_REG  = QED_FIRST_REG,
  parameter int LAST_REG   = QED_LAST_REG,
  parameter int DUP_OFFSET = QED_DUP_OFFSET,
  parameter int CNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  qed_consistency_checker_if.master  bus,
  output logic                       qed_stall,
  output logic                       qed_done,
  output logic                       qed_fail,
  output logic                       qed_err,
  output logic [REG_AW-1:0]          fail_reg,
  output logic [15:0]                check_cnt
);
  qed_state_e        state;
  logic [REG_AW-1:0] idx;
  logic              pend_zero;
  logic              consistent;
  logic              sweep_start;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;

  assign data_a      = bus.rf_rd_data_a;
  assign data_b      = bus.rf_rd_data_b;
  assign sweep_start = ena && (state == S_DRAIN) && pend_zero && bus.pipe_empty;

  qed_commit_tracker #(.CNT_W(CNT_W)) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .commit_vld  (bus.commit_vld),
    .commit_dup  (bus.commit_dup),
    .sweep_start (sweep_start),
    .pend_zero   (pend_zero),
    .consistent  (consistent),
    .qed_err     (qed_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      idx              <= REG_AW'(FIRST_REG);
      qed_stall        <= 1'b0;
      bus.rf_rd_req    <= 1'b0;
      bus.rf_rd_addr_a <= '0;
      bus.rf_rd_addr_b <= '0;
      qed_done         <= 1'b0;
      qed_fail         <= 1'b0;
      fail_reg         <= '0;
      check_cnt        <= '0;
    end else begin
      qed_done <= 1'b0;
      // Dropping QED mode abandons any sweep, but a detected failure stays frozen.
      if (!ena && state != S_HALT) begin
        state         <= S_IDLE;
        qed_stall     <= 1'b0;
        bus.rf_rd_req <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (consistent) begin
              state     <= S_DRAIN;
              qed_stall <= 1'b1;
            end
          end
          S_DRAIN: begin
            if (!pend_zero) begin
              state     <= S_IDLE;
              qed_stall <= 1'b0;
            end else if (sweep_start) begin
              state            <= S_REQ;
              idx              <= REG_AW'(FIRST_REG);
              bus.rf_rd_req    <= 1'b1;
              bus.rf_rd_addr_a <= REG_AW'(FIRST_REG);
              bus.rf_rd_addr_b <= REG_AW'(FIRST_REG + DUP_OFFSET);
            end
          end
          S_REQ: state <= S_WAIT;
          S_WAIT: begin
            if (bus.rf_rd_vld) begin
              if (data_a != data_b) begin
                state         <= S_HALT;
                bus.rf_rd_req <= 1'b0;
                qed_fail      <= 1'b1;
                fail_reg      <= idx;
              end else if (idx == REG_AW'(LAST_REG)) begin
                state         <= S_DONE;
                bus.rf_rd_req <= 1'b0;
                qed_done      <= 1'b1;
                check_cnt     <= check_cnt + 1'b1;
              end else begin
                state            <= S_REQ;
                idx              <= idx + 1'b1;
                bus.rf_rd_addr_a <= idx + 1'b1;
                bus.rf_rd_addr_b <= idx + 1'b1 + REG_AW'(DUP_OFFSET);
              end
            end
          end
          S_DONE: begin
            state     <= S_IDLE;
            qed_stall <= 1'b0;
          end
          S_HALT: state <= S_HALT;
          default: begin
            state     <= S_IDLE;
            qed_stall <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_qed_consistency_checker.sv
// Self-checking bench for qed_consistency_checker: commit-stream vector table,
// directed sweep scenarios and randomized streams/sweeps against a counting model.
module tb_qed_consistency_checker;
  import qed_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        qed_stall, qed_done, qed_fail, qed_err;
  logic [4:0]  fail_reg;
  logic [15:0] check_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rf  [32];
  int          lat [32];
  int          seen_q[$];

  qed_consistency_checker_if #(.DATA_W(32), .REG_AW(5)) bus ();

  qed_consistency_checker #(
    .DATA_W(32), .REG_AW(5), .FIRST_REG(1), .LAST_REG(15), .DUP_OFFSET(16), .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .bus       (bus.master),
    .qed_stall (qed_stall),
    .qed_done  (qed_done),
    .qed_fail  (qed_fail),
    .qed_err   (qed_err),
    .fail_reg  (fail_reg),
    .check_cnt (check_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register file: answers each new pair request after lat[original] cycles.
  initial begin : rf_model
    bit         pending = 1'b0;
    int         cnt = 0;
    logic [4:0] la = '0;
    logic [4:0] lb = '0;
    bus.rf_rd_vld    = 1'b0;
    bus.rf_rd_data_a = '0;
    bus.rf_rd_data_b = '0;
    forever begin
      @(negedge clk);
      bus.rf_rd_vld = 1'b0;
      if (!rst || !bus.rf_rd_req) begin
        pending = 1'b0;
      end else if (!pending) begin
        pending = 1'b1;
        la  = bus.rf_rd_addr_a;
        lb  = bus.rf_rd_addr_b;
        cnt = lat[la];
        seen_q.push_back(int'(la));
        check("dup_addr", 32'(lb), 32'(5'(la + 5'd16)));
      end else begin
        check("addr_hold", {bus.rf_rd_addr_a, bus.rf_rd_addr_b}, {la, lb});
        cnt--;
        if (cnt == 0) begin
          bus.rf_rd_vld    = 1'b1;
          bus.rf_rd_data_a = rf[la];
          bus.rf_rd_data_b = rf[lb];
          pending = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b0;
    ena = 1'b0;
    bus.commit_vld = 1'b0;
    bus.commit_dup = 1'b0;
    bus.pipe_empty = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    ena = 1'b1;
  endtask

  task automatic send(input bit dup);
    bus.commit_vld = 1'b1;
    bus.commit_dup = dup;
    @(posedge clk);
    #1;
    bus.commit_vld = 1'b0;
    bus.commit_dup = 1'b0;
  endtask

  task automatic fill_rf(input bit rnd);
    for (int i = 0; i < 16; i++) begin
      rf[i]      = rnd ? $urandom : 32'h1111 * i;
      rf[i + 16] = rf[i];
      lat[i]      = 1;
      lat[i + 16] = 1;
    end
    rf[16] = rf[0] ^ 32'h1;  // r0/r16 lie outside the checked range
  endtask

  // Two originals, their duplicates, then the sweep; outcome derived from rf/lat.
  task automatic run_sweep(input string tag);
    int          fail_idx = 0;
    int          s_sum = 0;
    int          exp_at;
    int          s = 0, stall_hi = 0, done_n = 0, done_at = -1, fail_at = -1, bad = 0;
    bit          fin = 1'b0;
    logic [15:0] cnt0;
    for (int i = QED_FIRST_REG; i <= QED_LAST_REG; i++) begin
      if (fail_idx == 0) begin
        s_sum += lat[i] + 1;
        if (rf[i] !== rf[i + QED_DUP_OFFSET]) fail_idx = i;
      end
    end
    exp_at = 2 + s_sum;
    cnt0 = check_cnt;
    seen_q.delete();
    bus.pipe_empty = 1'b1;
    send(0); send(0); send(1); send(1);
    for (int t = 0; t < 400 && !fin; t++) begin
      s++;
      if (qed_stall) stall_hi++;
      if (qed_done) begin done_n++; if (done_at < 0) done_at = s; end
      if (qed_fail && fail_at < 0) fail_at = s;
      if (!qed_stall) fin = 1'b1;
      else if (fail_at >= 0 && s >= fail_at + 4) fin = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check({tag, "_terminated"}, 32'(fin), 32'd1);
    for (int i = 0; i < seen_q.size(); i++) if (seen_q[i] != i + 1) bad++;
    check({tag, "_pair_order"}, 32'(bad), 32'd0);
    if (fail_idx == 0) begin
      check({tag, "_pairs_read"}, 32'(seen_q.size()), 32'd15);
      check({tag, "_stall_cycles"}, 32'(stall_hi), 32'(exp_at));
      check({tag, "_done_at"}, 32'(done_at), 32'(exp_at));
      check({tag, "_done_pulses"}, 32'(done_n), 32'd1);
      check({tag, "_check_cnt"}, 32'(check_cnt), 32'(16'(cnt0 + 16'd1)));
      check({tag, "_no_fail"}, 32'(qed_fail), 32'd0);
    end else begin
      check({tag, "_pairs_read"}, 32'(seen_q.size()), 32'(fail_idx));
      check({tag, "_fail_at"}, 32'(fail_at), 32'(exp_at));
      check({tag, "_fail_reg"}, 32'(fail_reg), 32'(fail_idx));
      check({tag, "_stall_stuck"}, 32'(stall_hi), 32'(s));
      check({tag, "_no_done"}, 32'(done_n), 32'd0);
      check({tag, "_check_cnt_kept"}, 32'(check_cnt), 32'(cnt0));
    end
  endtask

  typedef struct {
    logic vld;
    logic dup;
    logic en;
    logic exp_stall;
    logic exp_err;
  } vec_t;

  vec_t vecs[15];

  initial begin : main
    int  mcnt;
    bit  mdirty, merr;
    fill_rf(1'b0);

    // ---- reset state
    do_reset();
    check("rst_stall", 32'(qed_stall), 0);
    check("rst_req", 32'(bus.rf_rd_req), 0);
    check("rst_addr", {bus.rf_rd_addr_a, bus.rf_rd_addr_b}, 0);
    check("rst_done", 32'(qed_done), 0);
    check("rst_fail", 32'(qed_fail), 0);
    check("rst_err", 32'(qed_err), 0);
    check("rst_fail_reg", 32'(fail_reg), 0);
    check("rst_check_cnt", 32'(check_cnt), 0);

    // ---- commit-stream table (fetch never drains, so DRAIN holds)
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};  // dup without original
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};  // counts match -> DRAIN
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};  // late original -> IDLE
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};  // ena drop in DRAIN
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};  // suppressed
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 15; i++) begin
      ena = vecs[i].en;
      bus.commit_vld = vecs[i].vld;
      bus.commit_dup = vecs[i].dup;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_stall", i), 32'(qed_stall), 32'(vecs[i].exp_stall));
      check($sformatf("vec%0d_err", i), 32'(qed_err), 32'(vecs[i].exp_err));
    end
    bus.commit_vld = 1'b0;
    ena = 1'b1;

    // ---- passing sweep, L=1, then r9 with L=4, then ena drop in DRAIN
    do_reset();
    fill_rf(1'b0);
    run_sweep("pass_l1");
    lat[9] = 4;
    run_sweep("pass_r9_l4");
    lat[9] = 1;
    bus.pipe_empty = 1'b0;
    send(0); send(1);
    check("drain_stall", 32'(qed_stall), 1);
    ena = 1'b0;
    @(posedge clk); #1;
    check("ena_off_stall", 32'(qed_stall), 0);
    check("ena_off_req", 32'(bus.rf_rd_req), 0);
    check("ena_off_check_cnt", 32'(check_cnt), 2);
    ena = 1'b1;
    @(posedge clk); #1;
    check("ena_on_no_rearm", 32'(qed_stall), 0);

    // ---- counter saturation
    do_reset();
    repeat (255) send(0);
    check("sat255_err", 32'(qed_err), 0);
    send(0);
    check("sat256_err", 32'(qed_err), 1);
    repeat (254) send(1);
    check("sat_drain_early", 32'(qed_stall), 0);
    send(1);
    check("sat_drain", 32'(qed_stall), 1);

    // ---- mismatch r6/r22, HALT survives ena drop
    do_reset();
    fill_rf(1'b0);
    rf[6]  = 32'h4;
    rf[22] = 32'h5;
    run_sweep("fail_r6");
    ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("halt_ena_off_stall", 32'(qed_stall), 1);
    check("halt_ena_off_fail_reg", 32'(fail_reg), 6);
    ena = 1'b1;

    // ---- mismatch on the last pair
    do_reset();
    fill_rf(1'b0);
    rf[31] = rf[15] ^ 32'h8000_0000;
    run_sweep("fail_r15");

    // ---- reset during WAIT
    do_reset();
    fill_rf(1'b0);
    lat[5] = 20;
    bus.pipe_empty = 1'b1;
    send(0); send(1);
    repeat (12) @(posedge clk);
    #1;
    check("wait_req", 32'(bus.rf_rd_req), 1);
    check("wait_addr_a", 32'(bus.rf_rd_addr_a), 5);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_req", 32'(bus.rf_rd_req), 0);
    check("async_rst_stall", 32'(qed_stall), 0);
    check("async_rst_addr", {bus.rf_rd_addr_a, bus.rf_rd_addr_b}, 0);
    lat[5] = 1;

    // ---- random commit stream against an outstanding-count model
    do_reset();
    mcnt = 0; mdirty = 1'b0; merr = 1'b0;
    for (int t = 0; t < 400; t++) begin
      int kind;
      ena  = ($urandom_range(0, 15) != 0);
      kind = $urandom_range(0, 2);
      bus.commit_vld = (kind != 0);
      bus.commit_dup = (kind == 2);
      @(posedge clk);
      #1;
      if (!ena) begin
        mcnt = 0; mdirty = 1'b0;
      end else if (kind == 1) begin
        if (mcnt == 255) merr = 1'b1; else mcnt++;
        mdirty = 1'b1;
      end else if (kind == 2) begin
        if (mcnt == 0) merr = 1'b1;
        else begin mcnt--; mdirty = 1'b1; end
      end
      check("rnd_stall", 32'(qed_stall), 32'(mcnt == 0 && mdirty));
      check("rnd_err", 32'(qed_err), 32'(merr));
    end
    bus.commit_vld = 1'b0;
    ena = 1'b1;

    // ---- random sweeps: random contents, latencies and mismatch placement
    do_reset();
    for (int trial = 0; trial < 8; trial++) begin
      fill_rf(1'b1);
      for (int i = 1; i < 16; i++) lat[i] = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        int k;
        k = $urandom_range(1, 15);
        rf[k + 16] = rf[k + 16] ^ (32'h1 << $urandom_range(0, 31));
      end
      run_sweep($sformatf("rnd_sweep%0d", trial));
      if (qed_fail) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
